// File: rtl/ucode_asm_loader.sv
// rtl/ucode_asm_loader.sv - microcode program loader and instruction encoder
// Encodes symbolic instructions into 16-bit words and writes them sequentially to imem.
module ucode_asm_loader #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  start_addr,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [4:0]  req_kind,
   input  logic [2:0]  req_dst,
   input  logic [2:0]  req_src0,
   input  logic [2:0]  req_src1,
   input  logic [2:0]  req_imm,
   input  logic [1:0]  req_cc,
   input  logic [7:0]  req_target,
   input  logic        req_wren,
   input  logic        req_last,
   output logic        imem_wen,
   output logic [7:0]  imem_waddr,
   output logic [15:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  error_code,
   output logic [8:0]  count
);

   localparam logic [8:0] DEPTH_W   = 9'(DEPTH);
   localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

   localparam logic [4:0] K_NOP  = 5'd0,  K_JCC  = 5'd1,  K_PUSH = 5'd2,  K_POP  = 5'd3;
   localparam logic [4:0] K_LD   = 5'd4,  K_ST   = 5'd5,  K_MOV  = 5'd6,  K_MOVI = 5'd7;
   localparam logic [4:0] K_MOVS = 5'd8,  K_ADD  = 5'd9,  K_SUB  = 5'd10, K_ADDI = 5'd11;
   localparam logic [4:0] K_SUBI = 5'd12, K_CALL = 5'd13, K_RET  = 5'd14, K_WAIT = 5'd15;
   localparam logic [4:0] K_EMIT = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  addr_q;
   logic        wen_q;
   logic [7:0]  waddr_q;
   logic [15:0] wdata_q;
   logic [1:0]  code_q;
   logic [8:0]  count_q;

   logic [15:0] enc_d;
   logic        kind_bad_d;
   logic        tgt_bad_d;

   always_comb begin
      enc_d = 16'h0000;
      case (req_kind)
         K_NOP:  enc_d = 16'h0000;
         K_JCC:  enc_d = {4'h1, 2'b00, req_cc, req_target};
         K_PUSH: enc_d = {4'h2, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, req_src1};
         K_POP:  enc_d = {4'h2, 1'b1, req_dst, 8'h00};
         K_LD:   enc_d = {4'h4, 1'b0, req_dst, 1'b0, 3'b000, 1'b0, req_src1};
         K_ST:   enc_d = {4'h4, 1'b1, 3'b000, 1'b0, req_src0, 1'b0, req_src1};
         K_MOV:  enc_d = {4'h6, 1'b0, req_dst, 1'b0, 3'b000, 1'b0, req_src1};
         K_MOVI: enc_d = {4'h6, 1'b0, req_dst, 1'b0, 3'b000, 1'b1, req_imm};
         K_MOVS: enc_d = {4'h6, 1'b1, req_dst, 1'b0, 3'b000, 1'b0, req_imm};
         K_ADD:  enc_d = {4'h7, 1'b0, req_dst, req_wren, req_src0, 1'b0, req_src1};
         K_SUB:  enc_d = {4'h7, 1'b1, req_dst, req_wren, req_src0, 1'b0, req_src1};
         K_ADDI: enc_d = {4'h7, 1'b0, req_dst, req_wren, req_src0, 1'b1, req_imm};
         K_SUBI: enc_d = {4'h7, 1'b1, req_dst, req_wren, req_src0, 1'b1, req_imm};
         K_CALL: enc_d = {4'hC, 1'b0, 3'b000, req_target};
         K_RET:  enc_d = 16'hC800;
         K_WAIT: enc_d = 16'hF000;
         K_EMIT: enc_d = 16'hF800;
         default: enc_d = 16'h0000;
      endcase
   end

   assign kind_bad_d = (req_kind > K_EMIT);
   assign tgt_bad_d  = ((req_kind == K_JCC) || (req_kind == K_CALL)) &&
                       ({1'b0, req_target} >= DEPTH_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= 8'h00;
         wen_q   <= 1'b0;
         waddr_q <= 8'h00;
         wdata_q <= 16'h0000;
         code_q  <= 2'd0;
         count_q <= 9'd0;
      end else begin
         wen_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (req_vld) begin
                  if (kind_bad_d) begin
                     state_q <= S_ERR;
                     code_q  <= 2'd1;
                  end else if (tgt_bad_d) begin
                     state_q <= S_ERR;
                     code_q  <= 2'd2;
                  end else begin
                     wen_q   <= 1'b1;
                     waddr_q <= addr_q;
                     wdata_q <= enc_d;
                     if (count_q != DEPTH_W) count_q <= count_q + 9'd1;
                     // A last word in the final slot is a clean finish, not an overflow.
                     if (req_last) begin
                        state_q <= S_DONE;
                     end else if (addr_q == LAST_ADDR) begin
                        state_q <= S_ERR;
                        code_q  <= 2'd3;
                     end else begin
                        addr_q <= addr_q + 8'd1;
                     end
                  end
               end
            end
            default: begin
               if (start) begin
                  count_q <= 9'd0;
                  if ({1'b0, start_addr} >= DEPTH_W) begin
                     state_q <= S_ERR;
                     code_q  <= 2'd3;
                  end else begin
                     state_q <= S_LOAD;
                     addr_q  <= start_addr;
                     code_q  <= 2'd0;
                  end
               end
            end
         endcase
      end
   end

   assign req_rdy    = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);
   assign error_code = code_q;
   assign count      = count_q;
   assign imem_wen   = wen_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_ucode_asm_loader.sv
// tb/tb_ucode_asm_loader.sv - directed self-checking bench for ucode_asm_loader
// Instance a uses DEPTH 256, instance b uses DEPTH 16; both share the request inputs.
module tb_ucode_asm_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  start_addr;
   logic        req_vld;
   logic [4:0]  req_kind;
   logic [2:0]  req_dst;
   logic [2:0]  req_src0;
   logic [2:0]  req_src1;
   logic [2:0]  req_imm;
   logic [1:0]  req_cc;
   logic [7:0]  req_target;
   logic        req_wren;
   logic        req_last;

   logic        a_rdy, a_wen, a_busy, a_done, a_error;
   logic [7:0]  a_waddr;
   logic [15:0] a_wdata;
   logic [1:0]  a_code;
   logic [8:0]  a_count;

   logic        b_rdy, b_wen, b_busy, b_done, b_error;
   logic [7:0]  b_waddr;
   logic [15:0] b_wdata;
   logic [1:0]  b_code;
   logic [8:0]  b_count;

   int n_checks = 0;
   int n_fail   = 0;

   ucode_asm_loader #(.DEPTH(256)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .req_vld(req_vld), .req_rdy(a_rdy), .req_kind(req_kind), .req_dst(req_dst),
      .req_src0(req_src0), .req_src1(req_src1), .req_imm(req_imm), .req_cc(req_cc),
      .req_target(req_target), .req_wren(req_wren), .req_last(req_last),
      .imem_wen(a_wen), .imem_waddr(a_waddr), .imem_wdata(a_wdata),
      .busy(a_busy), .done(a_done), .error(a_error), .error_code(a_code), .count(a_count)
   );

   ucode_asm_loader #(.DEPTH(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .req_vld(req_vld), .req_rdy(b_rdy), .req_kind(req_kind), .req_dst(req_dst),
      .req_src0(req_src0), .req_src1(req_src1), .req_imm(req_imm), .req_cc(req_cc),
      .req_target(req_target), .req_wren(req_wren), .req_last(req_last),
      .imem_wen(b_wen), .imem_waddr(b_waddr), .imem_wdata(b_wdata),
      .busy(b_busy), .done(b_done), .error(b_error), .error_code(b_code), .count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] k, input logic [2:0] d, input logic [2:0] s0,
                        input logic [2:0] s1, input logic [2:0] im, input logic [1:0] c,
                        input logic [7:0] t, input logic w, input logic l);
      req_vld    = 1'b1;
      req_kind   = k;
      req_dst    = d;
      req_src0   = s0;
      req_src1   = s1;
      req_imm    = im;
      req_cc     = c;
      req_target = t;
      req_wren   = w;
      req_last   = l;
   endtask

   task automatic do_start(input logic [7:0] a);
      start      = 1'b1;
      start_addr = a;
      tick();
      start      = 1'b0;
   endtask

   task automatic one_kind(input string tag, input logic [4:0] k, input logic [2:0] d,
                           input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] im,
                           input logic [7:0] t, input logic [15:0] exp, input logic [7:0] addr);
      drive(k, d, s0, s1, im, 2'd0, t, 1'b0, 1'b0);
      tick();
      check({tag, "_wen"}, a_wen, 1);
      check({tag, "_data"}, a_wdata, exp);
      check({tag, "_addr"}, a_waddr, addr);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; req_vld = 1'b0;
      req_kind = 5'd0; req_dst = 3'd0; req_src0 = 3'd0; req_src1 = 3'd0;
      req_imm = 3'd0; req_cc = 2'd0; req_target = 8'h00; req_wren = 1'b0; req_last = 1'b0;
      tick();
      tick();
      check("rst_rdy", a_rdy, 0);
      check("rst_wen", a_wen, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_error", a_error, 0);
      check("rst_waddr", a_waddr, 0);
      check("rst_wdata", a_wdata, 0);
      check("rst_code", a_code, 0);
      check("rst_count", a_count, 0);
      rst_n = 1'b1;
      tick();

      // Four-instruction program at 0x10
      do_start(8'h10);
      check("p_busy", a_busy, 1);
      check("p_rdy", a_rdy, 1);
      drive(5'd11, 3'd2, 3'd1, 3'd0, 3'd3, 2'd0, 8'h00, 1'b1, 1'b0);
      tick();
      check("p0_wen", a_wen, 1);
      check("p0_data", a_wdata, 16'h729B);
      check("p0_addr", a_waddr, 8'h10);
      check("p0_count", a_count, 1);
      drive(5'd10, 3'd3, 3'd4, 3'd5, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0);
      tick();
      check("p1_wen", a_wen, 1);
      check("p1_data", a_wdata, 16'h7B45);
      check("p1_addr", a_waddr, 8'h11);
      drive(5'd1, 3'd0, 3'd0, 3'd0, 3'd0, 2'd2, 8'h2A, 1'b0, 1'b0);
      tick();
      check("p2_wen", a_wen, 1);
      check("p2_data", a_wdata, 16'h122A);
      check("p2_addr", a_waddr, 8'h12);
      drive(5'd16, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b1);
      tick();
      check("p3_wen", a_wen, 1);
      check("p3_data", a_wdata, 16'hF800);
      check("p3_addr", a_waddr, 8'h13);
      check("p3_done", a_done, 1);
      check("p3_count", a_count, 4);
      check("p3_rdy", a_rdy, 0);
      req_vld = 1'b0;
      tick();
      check("p_idle_wen", a_wen, 0);
      check("p_hold_data", a_wdata, 16'hF800);
      check("p_hold_done", a_done, 1);

      // Every valid kind, then a bad kind mid-program
      do_start(8'h20);
      one_kind("push", 5'd2,  3'd0, 3'd0, 3'd3, 3'd0, 8'h00, 16'h2003, 8'h20);
      one_kind("pop",  5'd3,  3'd5, 3'd0, 3'd0, 3'd0, 8'h00, 16'h2D00, 8'h21);
      one_kind("ld",   5'd4,  3'd1, 3'd0, 3'd2, 3'd0, 8'h00, 16'h4102, 8'h22);
      one_kind("st",   5'd5,  3'd0, 3'd6, 3'd1, 3'd0, 8'h00, 16'h4861, 8'h23);
      one_kind("mov",  5'd6,  3'd1, 3'd0, 3'd2, 3'd0, 8'h00, 16'h6102, 8'h24);
      one_kind("movi", 5'd7,  3'd1, 3'd0, 3'd0, 3'd5, 8'h00, 16'h610D, 8'h25);
      one_kind("movs", 5'd8,  3'd4, 3'd0, 3'd0, 3'd0, 8'h00, 16'h6C00, 8'h26);
      one_kind("call", 5'd13, 3'd0, 3'd0, 3'd0, 3'd0, 8'h10, 16'hC010, 8'h27);
      one_kind("ret",  5'd14, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 16'hC800, 8'h28);
      one_kind("wait", 5'd15, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 16'hF000, 8'h29);
      one_kind("nop",  5'd0,  3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 16'h0000, 8'h2A);
      drive(5'd20, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0);
      tick();
      check("bad_wen", a_wen, 0);
      check("bad_error", a_error, 1);
      check("bad_code", a_code, 1);
      check("bad_rdy", a_rdy, 0);
      check("bad_count", a_count, 11);
      req_vld = 1'b0;
      tick();
      check("bad_sticky", a_code, 1);
      do_start(8'h00);
      check("clr_error", a_error, 0);
      check("clr_code", a_code, 0);
      check("clr_busy", a_busy, 1);
      check("clr_count", a_count, 0);

      // Reset during a burst
      drive(5'd9, 3'd1, 3'd2, 3'd3, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0);
      tick();
      check("burst_wen", a_wen, 1);
      rst_n = 1'b0;
      #1;
      check("arst_wen", a_wen, 0);
      check("arst_busy", a_busy, 0);
      check("arst_rdy", a_rdy, 0);
      check("arst_waddr", a_waddr, 0);
      check("arst_wdata", a_wdata, 0);
      check("arst_count", a_count, 0);
      tick();
      check("arst_hold_wen", a_wen, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_wen", a_wen, 0);
         check("post_rst_rdy", a_rdy, 0);
      end
      req_vld = 1'b0;

      // DEPTH 16 overflow
      do_start(8'd14);
      check("ov_busy", b_busy, 1);
      drive(5'd6, 3'd1, 3'd0, 3'd2, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0);
      tick();
      check("ov0_wen", b_wen, 1);
      check("ov0_addr", b_waddr, 14);
      check("ov0_error", b_error, 0);
      tick();
      check("ov1_wen", b_wen, 1);
      check("ov1_addr", b_waddr, 15);
      check("ov1_error", b_error, 1);
      check("ov1_code", b_code, 3);
      check("ov1_rdy", b_rdy, 0);
      tick();
      check("ov2_wen", b_wen, 0);
      check("ov2_count", b_count, 2);
      req_vld = 1'b0;

      // DEPTH 16 last word in the final slot
      do_start(8'd15);
      drive(5'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b1);
      tick();
      check("edge_wen", b_wen, 1);
      check("edge_done", b_done, 1);
      check("edge_error", b_error, 0);
      req_vld = 1'b0;

      // DEPTH 16 target out of range, then bad start address
      do_start(8'd0);
      drive(5'd13, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd16, 1'b0, 1'b0);
      tick();
      check("tgt_wen", b_wen, 0);
      check("tgt_error", b_error, 1);
      check("tgt_code", b_code, 2);
      check("tgt_count", b_count, 0);
      req_vld = 1'b0;
      do_start(8'd16);
      check("sa_error", b_error, 1);
      check("sa_code", b_code, 3);
      check("sa_busy", b_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
